// File: rtl/cfi_shadow_stack_monitor_pkg.sv
// Shared types for the commit-stage CFI monitor.
// Commit entry subset, call/return classes, classifier helpers.
package cfi_shadow_stack_monitor_pkg;

  localparam int unsigned VLEN = 64;
  localparam int unsigned NR_COMMIT_PORTS = 2;

  typedef enum logic [3:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR,
    FPU
  } fu_t;

  typedef enum logic [7:0] {
    ADD,
    SUB,
    XORL,
    ORL,
    ANDL,
    SLTS,
    JALR,
    EQ,
    NE,
    LW
  } fu_op;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    fu_t             fu;
    fu_op            op;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic            is_compressed;
  } scoreboard_entry_t;

  typedef enum logic [2:0] {
    CFI_NONE,
    CFI_CALL,
    CFI_RET,
    CFI_CORO,
    CFI_NOP
  } cfi_class_e;

  function automatic logic is_link_reg(
    input logic [4:0] r
  );
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Conditions are made disjoint so the decoder can be unique.
  function automatic cfi_class_e classify(
    input scoreboard_entry_t e
  );
    logic rd_l;
    logic rs_l;
    logic jal;
    logic jalr;
    logic coro;
    logic call;
    logic ret;
    logic nop;
    cfi_class_e c;
    rd_l = is_link_reg(e.rd);
    rs_l = is_link_reg(e.rs1);
    jal  = (e.fu == CTRL_FLOW) && (e.op == ADD);
    jalr = (e.fu == CTRL_FLOW) && (e.op == JALR);
    coro = jalr && rd_l && rs_l
         && (e.rd != e.rs1);
    call = rd_l && (jal || (jalr && !coro));
    ret  = jalr && rs_l && !rd_l;
    nop  = (e.fu == ALU) && (e.op == ADD)
         && (e.rd == 5'd0);
    unique case (1'b1)
      coro:    c = CFI_CORO;
      call:    c = CFI_CALL;
      ret:     c = CFI_RET;
      nop:     c = CFI_NOP;
      default: c = CFI_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [VLEN-1:0] ret_addr(
    input scoreboard_entry_t e
  );
    return e.pc + (e.is_compressed
                   ? VLEN'(2) : VLEN'(4));
  endfunction

endpackage

// File: rtl/cfi_shadow_stack_monitor_ras.sv
// Circular shadow return-address stack, several push/pop ops per cycle.
// Ports: clk_i, rst_ni, clear_i, push_i/push_data_i, pop_i -> pop_hit_o/pop_data_o, ovf_o, ufl_o, level_o.
module cfi_shadow_stack_monitor_ras
  import cfi_shadow_stack_monitor_pkg::*;
#(
  parameter int unsigned NR_PORTS  = 2,
  parameter int unsigned RAS_DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic [NR_PORTS-1:0]           push_i,
  input  logic [NR_PORTS-1:0][VLEN-1:0] push_data_i,
  input  logic [NR_PORTS-1:0]           pop_i,
  output logic [NR_PORTS-1:0]           pop_hit_o,
  output logic [NR_PORTS-1:0][VLEN-1:0] pop_data_o,
  output logic                          ovf_o,
  output logic                          ufl_o,
  output logic [LVL_W-1:0]              level_o
);

  localparam logic [LVL_W-1:0] FULL = LVL_W'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][VLEN-1:0] mem_q;
  logic [RAS_DEPTH-1:0][VLEN-1:0] mem_d;
  logic [PTR_W-1:0]               ptr_q;
  logic [PTR_W-1:0]               ptr_d;
  logic [LVL_W-1:0]               lvl_q;
  logic [LVL_W-1:0]               lvl_d;

  // ptr points at the next free slot.
  // Each port pops then pushes, so a
  // coroutine swap is one stage.
  // A push on a full stack reuses the
  // oldest slot because ptr wraps.
  always_comb begin
    mem_d      = mem_q;
    ptr_d      = ptr_q;
    lvl_d      = lvl_q;
    pop_hit_o  = '0;
    pop_data_o = '0;
    ovf_o      = 1'b0;
    ufl_o      = 1'b0;
    for (int i = 0; i < NR_PORTS; i++) begin
      if (pop_i[i]) begin
        if (lvl_d == '0) begin
          ufl_o = 1'b1;
        end else begin
          ptr_d         = ptr_d - PTR_W'(1);
          lvl_d         = lvl_d - LVL_W'(1);
          pop_hit_o[i]  = 1'b1;
          pop_data_o[i] = mem_d[ptr_d];
        end
      end
      if (push_i[i]) begin
        mem_d[ptr_d] = push_data_i[i];
        ptr_d        = ptr_d + PTR_W'(1);
        if (lvl_d == FULL) begin
          ovf_o = 1'b1;
        end else begin
          lvl_d = lvl_d + LVL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      lvl_q <= '0;
    end else if (clear_i) begin
      ptr_q <= '0;
      lvl_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      lvl_q <= lvl_d;
    end
  end

  // Entries above the level are dead,
  // so the RAM itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      mem_q <= mem_d;
    end
  end

  assign level_o = lvl_q;

endmodule

// File: rtl/cfi_shadow_stack_monitor.sv
// Commit-stage CFI monitor: shadow RAS return checks and NOP-sled detection.
// Ports: clk_i, rst_ni, en_i, clear_i, commit_*_i in; ret_mismatch_o, mismatch_port_o, nop_sled_o, ras_*_o out.
module cfi_shadow_stack_monitor
  import cfi_shadow_stack_monitor_pkg::*;
#(
  parameter int unsigned NR_PORTS     = NR_COMMIT_PORTS,
  parameter int unsigned RAS_DEPTH    = 16,
  parameter int unsigned NOP_THRESH   = 8,
  parameter bit          STRICT_UFLOW = 1'b0,
  localparam int unsigned PORT_W =
    (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
  localparam int unsigned LVL_W =
    $clog2(RAS_DEPTH) + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_i,
  input  logic                              clear_i,
  input  scoreboard_entry_t [NR_PORTS-1:0]  commit_instr_i,
  input  logic [NR_PORTS-1:0]               commit_ack_i,
  input  logic [NR_PORTS-1:0][VLEN-1:0]     commit_npc_i,
  output logic                              ret_mismatch_o,
  output logic [PORT_W-1:0]                 mismatch_port_o,
  output logic                              nop_sled_o,
  output logic                              ras_ovf_o,
  output logic                              ras_ufl_o,
  output logic [LVL_W-1:0]                  ras_level_o
);

  logic [NR_PORTS-1:0]           act;
  logic [NR_PORTS-1:0]           push;
  logic [NR_PORTS-1:0]           pop;
  logic [NR_PORTS-1:0]           nop;
  logic [NR_PORTS-1:0][VLEN-1:0] push_data;
  logic [NR_PORTS-1:0]           pop_hit;
  logic [NR_PORTS-1:0][VLEN-1:0] pop_data;
  logic                          ovf;
  logic                          ufl;
  logic [NR_PORTS-1:0]           mm;
  logic [PORT_W-1:0]             mm_port;
  logic [7:0]                    cnt_d;
  logic [7:0]                    cnt_q;
  logic                          mm_q;
  logic [PORT_W-1:0]             port_q;
  logic                          sled_q;
  logic                          ovf_q;
  logic                          ufl_q;

  always_comb begin
    act       = '0;
    push      = '0;
    pop       = '0;
    nop       = '0;
    push_data = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      cfi_class_e c;
      c            = classify(commit_instr_i[i]);
      act[i]       = commit_ack_i[i] && en_i;
      push[i]      = act[i] &&
                     (c == CFI_CALL || c == CFI_CORO);
      pop[i]       = act[i] &&
                     (c == CFI_RET || c == CFI_CORO);
      nop[i]       = act[i] && (c == CFI_NOP);
      push_data[i] = ret_addr(commit_instr_i[i]);
    end
  end

  cfi_shadow_stack_monitor_ras #(
    .NR_PORTS  (NR_PORTS),
    .RAS_DEPTH (RAS_DEPTH)
  ) i_ras (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_hit_o   (pop_hit),
    .pop_data_o  (pop_data),
    .ovf_o       (ovf),
    .ufl_o       (ufl),
    .level_o     (ras_level_o)
  );

  // Empty-stack pops only flag in
  // strict mode; there is no top.
  always_comb begin
    mm      = '0;
    mm_port = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      mm[i] = pop[i] &&
              (pop_hit[i]
               ? (pop_data[i] != commit_npc_i[i])
               : STRICT_UFLOW);
    end
    for (int i = NR_PORTS - 1; i >= 0; i--) begin
      if (mm[i]) begin
        mm_port = PORT_W'(i);
      end
    end
  end

  // Walk ports in order: NOPs count up,
  // any other commit restarts the run.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NR_PORTS; i++) begin
      if (act[i]) begin
        if (!nop[i]) begin
          cnt_d = '0;
        end else if (cnt_d != 8'hff) begin
          cnt_d = cnt_d + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      mm_q   <= 1'b0;
      port_q <= '0;
      sled_q <= 1'b0;
      ovf_q  <= 1'b0;
      ufl_q  <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      mm_q   <= 1'b0;
      port_q <= '0;
      sled_q <= 1'b0;
      ovf_q  <= 1'b0;
      ufl_q  <= 1'b0;
    end else if (en_i) begin
      cnt_q  <= cnt_d;
      mm_q   <= |mm;
      sled_q <= cnt_d >= 8'(NOP_THRESH);
      ovf_q  <= ovf_q | ovf;
      ufl_q  <= ufl_q | ufl;
      if (|mm) begin
        port_q <= mm_port;
      end
    end else begin
      mm_q <= 1'b0;
    end
  end

  assign ret_mismatch_o  = mm_q;
  assign mismatch_port_o = port_q;
  assign nop_sled_o      = sled_q;
  assign ras_ovf_o       = ovf_q;
  assign ras_ufl_o       = ufl_q;

endmodule
